// File: rtl/lif_pkg.sv
// Shared constants for the RC LIF neuron and its spike monitor.
// Neuron and monitor both import this package so they agree on widths and the threshold.
package lif_pkg;
  localparam int ISI_W_DEF      = 16;
  localparam int CNT_W_DEF      = 16;
  localparam int VMEM_W         = 16;
  localparam int WINDOW_DEF     = 1000;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int VTH            = 50;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction
endpackage

// File: rtl/lif_isi_fifo.sv
// First-word-fall-through FIFO for ISI values.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module lif_isi_fifo
  import lif_pkg::*;
#(
  parameter int W     = ISI_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic [ptr_w(DEPTH):0] count,
  output logic                  full,
  output logic                  empty
);
  localparam int PW = ptr_w(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/lif_spike_monitor.sv
// Spike monitor: measures inter-spike intervals into a FIFO and reports
// the spike count of each fixed-length window.
module lif_spike_monitor
  import lif_pkg::*;
#(
  parameter int ISI_W      = ISI_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WINDOW     = WINDOW_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [VMEM_W-1:0]          V_out,
  input  logic                       clear_ovf,
  input  logic                       isi_ready,
  output logic                       isi_valid,
  output logic [ISI_W-1:0]           isi_data,
  output logic [ptr_w(FIFO_DEPTH):0] fifo_count,
  output logic                       overflow,
  output logic [CNT_W-1:0]           spike_rate,
  output logic                       rate_valid
);
  localparam int                WIN_W    = ptr_w(WINDOW);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [ISI_W-1:0]  ISI_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  logic             prev;
  logic             armed;
  logic [ISI_W-1:0] isi_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] spk_cnt;
  logic [CNT_W-1:0] spk_next;
  logic             evt;
  logic             push;
  logic             drop;
  logic             full;
  logic             empty;
  logic             unused_vout_bits;

  assign unused_vout_bits = ^V_out[VMEM_W-1:1];

  assign evt       = enable & V_out[0] & ~prev;
  assign push      = evt & armed;
  assign isi_valid = ~empty;
  // A full FIFO only accepts the new ISI if the consumer frees the head this cycle.
  assign drop      = push & full & ~isi_ready;
  assign spk_next  = (evt && spk_cnt != CNT_MAX) ? spk_cnt + 1'b1 : spk_cnt;

  lif_isi_fifo #(
    .W     (ISI_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (isi_cnt),
    .pop       (isi_ready),
    .head      (isi_data),
    .count     (fifo_count),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= 1'b0;
      armed      <= 1'b0;
      isi_cnt    <= '0;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      spike_rate <= '0;
      rate_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prev       <= V_out[0];
      rate_valid <= 1'b0;
      if (!enable) begin
        armed   <= 1'b0;
        isi_cnt <= '0;
        win_cnt <= '0;
        spk_cnt <= '0;
      end else begin
        if (evt) begin
          armed   <= 1'b1;
          isi_cnt <= ISI_W'(1);
        end else if (armed && isi_cnt != ISI_MAX) begin
          isi_cnt <= isi_cnt + 1'b1;
        end
        if (win_cnt == WIN_LAST) begin
          spike_rate <= spk_next;
          rate_valid <= 1'b1;
          win_cnt    <= '0;
          spk_cnt    <= '0;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          spk_cnt <= spk_next;
        end
      end
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end
endmodule
